// File: rtl/mmm_seq_ctrl_pkg.sv
// Shared definitions for the Montgomery multiplier sequencer: datapath
// register enable codes and the sequencer state encoding.
package mmm_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    DO_NOTHING    = 2'b00,
    SHIFT_LEFT    = 2'b01,
    SHIFT_RIGHT   = 2'b10,
    PARALLEL_LOAD = 2'b11
  } en_code_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    CHECK = 4'd2,
    LOAD  = 4'd3,
    SHIFT = 4'd4,
    ACC   = 4'd5,
    ACC2  = 4'd6,
    FINAL = 4'd7,
    SUB   = 4'd8,
    DONE  = 4'd9
  } state_t;

endpackage

// File: rtl/mmm_seq_ctrl_iter.sv
// Bit-iteration counter for the Montgomery sequencer. Clears, advances by
// one or two bits, and flags whether iterations remain and whether at least
// two bits remain (needed to decide on a second radix-4 accumulate).
module mmm_iter_cnt #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc1,
  input  logic          i_inc2,
  input  logic [CW-1:0] i_n,
  output logic          o_lt_n,
  output logic          o_ge2
);

  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_p2;

  // Counter register: clear has priority, then two-bit and one-bit steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc2) begin
      r_cnt <= r_cnt + CW'(2);
    end else if (i_inc1) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Remaining-bit flags; cnt+2 is formed one bit wider so it cannot wrap
  always_comb begin
    w_cnt_p2 = {1'b0, r_cnt} + (CW+1)'(2);
    o_lt_n   = (r_cnt < i_n);
    o_ge2    = (w_cnt_p2 <= {1'b0, i_n});
  end

endmodule

// File: rtl/mmm_seq_ctrl.sv
// Sequencer for the Montgomery modular multiplier datapath. Runs n
// bit-iterations in radix-2 or radix-4 mode, then the conditional final
// subtraction, with a start/busy/done handshake and synchronous abort.
module mmm_seq_ctrl
  import mmm_seq_ctrl_pkg::*;
#(
  parameter  int unsigned M  = 8,
  localparam int unsigned CW = $clog2(M+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          radix4,
  input  logic [CW-1:0] n,
  input  logic          ge_mod,
  output logic [1:0]    r1_en,
  output logic [1:0]    sr1_en,
  output logic [1:0]    sr2_en,
  output logic          clr_r1,
  output logic          clr_sr1,
  output logic          clr_sr2,
  output logic          sub_en,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] N_MAX = CW'(M);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_n_l;
  logic          r_radix4;
  logic          w_latch;
  logic          w_clr;
  logic          w_inc1;
  logic          w_inc2;
  logic          w_lt_n;
  logic          w_ge2;

  mmm_iter_cnt #(.CW(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc1 (w_inc1),
    .i_inc2 (w_inc2),
    .i_n    (r_n_l),
    .o_lt_n (w_lt_n),
    .o_ge2  (w_ge2)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation parameters captured when a request is accepted; n is clamped to M
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_l    <= '0;
      r_radix4 <= 1'b0;
    end else if (w_latch) begin
      r_n_l    <= (n > N_MAX) ? N_MAX : n;
      r_radix4 <= radix4;
    end
  end

  // Next state and counter control; abort overrides every transition and
  // suppresses counter updates so the count is left stale until INIT
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clr       = 1'b0;
    w_inc1      = 1'b0;
    w_inc2      = 1'b0;
    if (r_state != IDLE && abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            w_latch     = 1'b1;
            w_state_nxt = INIT;
          end
        end
        INIT: begin
          w_clr       = 1'b1;
          w_state_nxt = CHECK;
        end
        CHECK: w_state_nxt = w_lt_n ? LOAD : FINAL;
        LOAD:  w_state_nxt = SHIFT;
        SHIFT: w_state_nxt = ACC;
        ACC: begin
          if (r_radix4 && w_ge2) begin
            w_state_nxt = ACC2;
          end else begin
            w_inc1      = 1'b1;
            w_state_nxt = CHECK;
          end
        end
        ACC2: begin
          w_inc2      = 1'b1;
          w_state_nxt = CHECK;
        end
        FINAL:   w_state_nxt = ge_mod ? SUB : DONE;
        SUB:     w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    r1_en   = DO_NOTHING;
    sr1_en  = DO_NOTHING;
    sr2_en  = DO_NOTHING;
    clr_r1  = 1'b0;
    clr_sr1 = 1'b0;
    clr_sr2 = 1'b0;
    sub_en  = 1'b0;
    busy    = (r_state != IDLE);
    done    = 1'b0;
    case (r_state)
      INIT: begin
        sr1_en  = PARALLEL_LOAD;
        clr_r1  = 1'b1;
        clr_sr2 = 1'b1;
      end
      LOAD:  sr2_en = PARALLEL_LOAD;
      SHIFT: sr2_en = SHIFT_RIGHT;
      ACC: begin
        r1_en  = PARALLEL_LOAD;
        sr1_en = SHIFT_RIGHT;
      end
      ACC2:  sr1_en = SHIFT_RIGHT;
      SUB: begin
        r1_en  = PARALLEL_LOAD;
        sub_en = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
